// File: rtl/mulf_pipe.sv
// Pipelined sign/exponent/mantissa multiplier; operands accepted on edge N give out_valid after edge N+3.
// Backpressure: a held output (out_valid && !out_ready) freezes every stage and drops in_ready.
module mulf_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int ROUND = 1,
  parameter int TAG_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_p,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_ovf,
  output logic                   out_unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;
  localparam int PW = 2 * MW;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]     EXP_FIN  = EXP_W'((1 << EXP_W) - 2);

  logic stall;
  logic s1_vld, s2_vld, s3_vld, so_vld;

  // Stage 1: decode
  logic                   s1_sign, s1_zero;
  logic signed [EW-1:0]   s1_exp;
  logic [MW-1:0]          s1_ma, s1_mb;
  logic [TAG_W-1:0]       s1_tag;

  // Stage 2: mantissa product
  logic                   s2_sign, s2_zero;
  logic signed [EW-1:0]   s2_exp;
  logic [PW-1:0]          s2_prod;
  logic [TAG_W-1:0]       s2_tag;

  // Stage 3: normalized and rounded
  logic                   s3_sign, s3_zero;
  logic signed [EW-1:0]   s3_exp;
  logic [MAN_W-1:0]       s3_frac;
  logic [TAG_W-1:0]       s3_tag;

  logic [EXP_W-1:0] ea, eb;
  assign ea = in_a[W-2 -: EXP_W];
  assign eb = in_b[W-2 -: EXP_W];

  assign stall     = so_vld && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = so_vld;

  // Normalize / round from the registered product
  logic [PW-1:0]         norm;
  logic [MAN_W-1:0]      frac_t, frac_r;
  logic                  guard, sticky, rnd, carry;
  logic signed [EW-1:0]  exp_n;

  always_comb begin
    norm   = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    frac_t = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    rnd    = (ROUND != 0) && guard && (sticky || frac_t[0]);
    {carry, frac_r} = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd};
    exp_n  = s2_exp + $signed({{(EW-1){1'b0}}, s2_prod[PW-1]})
                    + $signed({{(EW-1){1'b0}}, carry});
  end

  // Exception handling on the rounded result
  logic [W-1:0] res_p;
  logic         res_ovf, res_unf;

  always_comb begin
    res_p   = '0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (s3_zero) begin
      res_p = '0;
    end else if (s3_exp <= EXP_ZERO) begin
      res_unf = 1'b1;
    end else if (s3_exp >= EXP_MAX) begin
      res_p   = {s3_sign, EXP_FIN, {MAN_W{1'b1}}};
      res_ovf = 1'b1;
    end else begin
      res_p = {s3_sign, s3_exp[EXP_W-1:0], s3_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      so_vld  <= 1'b0;
      out_p   <= '0;
      out_tag <= '0;
      out_ovf <= 1'b0;
      out_unf <= 1'b0;
    end else if (!stall) begin
      s1_vld  <= in_valid;
      s2_vld  <= s1_vld;
      s3_vld  <= s2_vld;
      so_vld  <= s3_vld;
      out_p   <= res_p;
      out_tag <= s3_tag;
      out_ovf <= res_ovf;
      out_unf <= res_unf;
    end
  end

  // Datapath registers need no reset: valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign <= in_a[W-1] ^ in_b[W-1];
      s1_zero <= (ea == '0) || (eb == '0);
      s1_exp  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      s1_ma   <= {1'b1, in_a[MAN_W-1:0]};
      s1_mb   <= {1'b1, in_b[MAN_W-1:0]};
      s1_tag  <= in_tag;

      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_tag  <= s1_tag;

      s3_sign <= s2_sign;
      s3_zero <= s2_zero;
      s3_exp  <= exp_n;
      s3_frac <= frac_r;
      s3_tag  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_mulf_pipe.sv
// Directed bench for mulf_pipe: vector table run on ROUND=1 and ROUND=0 instances, then stall and reset sequences.
module tb_mulf_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = '0, in_b = '0;
  logic [5:0]  in_tag = '0;

  logic        in_ready, out_valid, out_ovf, out_unf;
  logic [15:0] out_p;
  logic [5:0]  out_tag;

  logic        r0_in_ready, r0_out_valid, r0_out_ovf, r0_out_unf;
  logic [15:0] r0_out_p;
  logic [5:0]  r0_out_tag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mulf_pipe #(.EXP_W(8), .MAN_W(7), .ROUND(1), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  mulf_pipe #(.EXP_W(8), .MAN_W(7), .ROUND(0), .TAG_W(6)) dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(r0_out_valid),
    .out_ready(out_ready), .out_p(r0_out_p), .out_tag(r0_out_tag),
    .out_ovf(r0_out_ovf), .out_unf(r0_out_unf)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p1;
    logic        ovf1;
    logic        unf1;
    logic [15:0] p0;
    logic        ovf0;
    logic        unf0;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Issue one op into an empty pipe and count edges until out_valid appears.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] tag, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int nsent, nrecv, cyc, stalls, seen;
    logic have_prev;
    logic [15:0] prev_p;
    logic [5:0]  prev_tag;

    //            a        b        p1       o1    u1    p0       o0    u0
    vecs[0]  = '{16'h3FC0, 16'h4000, 16'h4040, 1'b0, 1'b0, 16'h4040, 1'b0, 1'b0};
    vecs[1]  = '{16'hBFC0, 16'h3FC0, 16'hC010, 1'b0, 1'b0, 16'hC010, 1'b0, 1'b0};
    vecs[2]  = '{16'h0000, 16'hC2F0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{16'h0055, 16'hC2F0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{16'h3FC0, 16'h3F81, 16'h3FC2, 1'b0, 1'b0, 16'h3FC1, 1'b0, 1'b0};
    vecs[5]  = '{16'h3FFF, 16'h3FFF, 16'h407E, 1'b0, 1'b0, 16'h407E, 1'b0, 1'b0};
    vecs[6]  = '{16'h7F00, 16'h4000, 16'h7F7F, 1'b1, 1'b0, 16'h7F7F, 1'b1, 1'b0};
    vecs[7]  = '{16'hFF00, 16'h4000, 16'hFF7F, 1'b1, 1'b0, 16'hFF7F, 1'b1, 1'b0};
    vecs[8]  = '{16'h0080, 16'h3F00, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{16'h3FC0, 16'h3F83, 16'h3FC4, 1'b0, 1'b0, 16'h3FC4, 1'b0, 1'b0};
    vecs[10] = '{16'h3F97, 16'h3FD9, 16'h4000, 1'b0, 1'b0, 16'h3FFF, 1'b0, 1'b0};
    vecs[11] = '{16'h7F17, 16'h3FD9, 16'h7F7F, 1'b1, 1'b0, 16'h7F7F, 1'b0, 1'b0};
    vecs[12] = '{16'h0097, 16'h3F59, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{16'h7F00, 16'h3F80, 16'h7F00, 1'b0, 1'b0, 16'h7F00, 1'b0, 1'b0};
    vecs[14] = '{16'h8000, 16'h3F80, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_out_unf", 32'(out_unf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      logic [5:0] tag;
      tag = 6'(i + 5);
      run_op(vecs[i].a, vecs[i].b, tag, lat);
      check($sformatf("latency[%0d]", i), 32'(lat), 32'd3);
      check($sformatf("trunc_valid[%0d]", i), 32'(r0_out_valid), 32'd1);
      check($sformatf("p_rne[%0d]", i), 32'(out_p), 32'(vecs[i].p1));
      check($sformatf("ovf_rne[%0d]", i), 32'(out_ovf), 32'(vecs[i].ovf1));
      check($sformatf("unf_rne[%0d]", i), 32'(out_unf), 32'(vecs[i].unf1));
      check($sformatf("tag[%0d]", i), 32'(out_tag), 32'(tag));
      check($sformatf("p_trunc[%0d]", i), 32'(r0_out_p), 32'(vecs[i].p0));
      check($sformatf("ovf_trunc[%0d]", i), 32'(r0_out_ovf), 32'(vecs[i].ovf0));
      check($sformatf("unf_trunc[%0d]", i), 32'(r0_out_unf), 32'(vecs[i].unf0));
    end

    // Backpressure: 6 back-to-back ops, consumer stalls 4 cycles mid-stream
    @(negedge clk);
    nsent = 0; nrecv = 0; cyc = 0; stalls = 0; have_prev = 1'b0;
    prev_p = '0; prev_tag = '0;
    while (nrecv < 6 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      in_valid = (nsent < 6);
      in_a = 16'h3F80 | 16'(nsent);
      in_b = 16'h4000;
      in_tag = 6'(nsent);
      #1;
      if (have_prev) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_p", 32'(out_p), 32'(prev_p));
        check("stall_hold_tag", 32'(out_tag), 32'(prev_tag));
        have_prev = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("bp_p[%0d]", nrecv), 32'(out_p), 32'(16'h4000 | 16'(nrecv)));
          check($sformatf("bp_tag[%0d]", nrecv), 32'(out_tag), 32'(nrecv));
          nrecv++;
        end else begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          prev_p = out_p;
          prev_tag = out_tag;
          have_prev = 1'b1;
          stalls++;
        end
      end
      if (in_valid && in_ready) nsent++;
      cyc++;
    end
    check("bp_received", 32'(nrecv), 32'd6);
    check("bp_stall_cycles", 32'(stalls), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_no_duplicates", 32'(seen), 32'd0);

    // Reset while three ops are in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 16'h3FC0;
      in_b = 16'h4000;
      in_tag = 6'(40 + k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_p", 32'(out_p), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_ghosts", 32'(seen), 32'd0);
    run_op(16'h3FC0, 16'h4000, 6'd50, lat);
    check("postrst_latency", 32'(lat), 32'd3);
    check("postrst_p", 32'(out_p), 32'h4040);
    check("postrst_tag", 32'(out_tag), 32'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mulf_pipe.md
Name: mulf_pipe

Overview:
- Parametrised, pipelined successor to the combinational float multiplier.
- Multiplies two sign/exponent/mantissa floats in a fixed 3-stage pipeline with valid/ready handshake and backpressure.
- Selectable rounding, saturating overflow, underflow-to-zero, status flags and a pass-through tag.
- Sits between the stage-2 operand latch and stage-4 writeback of the processor pipeline, so the ALU can issue one MULF per cycle.

Parameters:
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 7: stored fraction width; hidden leading 1 is implied.
- ROUND, 1: 0 = truncate (legacy MULF results), 1 = round-to-nearest-even.
- TAG_W, 6: width of the opaque tag (destination register index) carried with each operation.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands this cycle.
- in_a  input  1+EXP_W+MAN_W  operand A: sign, exponent, fraction (MSB to LSB).
- in_b  input  1+EXP_W+MAN_W  operand B.
- in_tag  input  TAG_W  tag accompanying the operands.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_p  output  1+EXP_W+MAN_W  product.
- out_tag  output  TAG_W  tag of the product.
- out_ovf  output  1  result saturated on overflow.
- out_unf  output  1  result flushed to zero on underflow.

Behaviour:
- Reset: synchronous, active-high, one clk edge. Clears all stage valid bits. out_valid=0, out_p=0, out_tag=0, out_ovf=0, out_unf=0, in_ready=1 after the edge. Reset mid-operation discards all in-flight operations; no partial result appears.
- Handshake: transfer occurs when valid && ready on a posedge. stall = out_valid && !out_ready.
  - When stall is high, all three stages hold; in_ready = !stall.
  - In-flight data and out_* are stable while stalled.
  - Bubbles are allowed: stage valid bits advance independently of data.
- Latency: operands accepted at edge N produce out_valid=1 after edge N+3, absent stall. Throughput is one operation per cycle. Order is preserved.
- S1:
  - An operand with exponent field 0 is zero, regardless of fraction or sign.
  - Register sign = a.s XOR b.s.
  - Register exponent sum in EXP_W+2 bits signed: ea+eb-bias.
  - Register the zero flag, both mantissas with hidden 1 prepended, and the tag.
- S2: unsigned (MAN_W+1)x(MAN_W+1) product, 2*MAN_W+2 bits, registered.
- S3 (normalize and round):
  - If product MSB=1: exponent+1, fraction = the next MAN_W bits. Otherwise use the MAN_W bits after the second MSB.
  - Guard = first discarded bit; sticky = OR of the remaining discarded bits.
  - With ROUND=1, increment the fraction when guard && (sticky || fraction LSB).
  - A round carry-out of the fraction sets fraction=0 and exponent+1.
  - ROUND=0 ignores guard and sticky.
- Exceptions, checked after rounding:
  - Zero flag set: out_p = all zeros (positive zero); ovf=0, unf=0.
  - Exponent <= 0: out_p = all zeros, out_unf=1.
  - Exponent >= 2^EXP_W-1: out_p = {sign, 2^EXP_W-2, all-ones fraction} (max finite), out_ovf=1.
  - Exponent field all-ones is never produced.
- Flags and tag are valid only while out_valid=1; they travel with their operation.

Test Plan (defaults EXP_W=8, MAN_W=7, ROUND=1, TAG_W=6):
1. Basic multiply and latency: reset 2 cycles, then a=0x3FC0 (1.5), b=0x4000 (2.0), tag=5, out_ready=1. Required: out_p=0x4040, out_tag=5, out_valid high exactly 3 edges after acceptance, flags 0.
2. Sign and zero: a=0xBFC0, b=0x3FC0 -> 0xC010. Then a=0x0000 or a=0x0055 (exponent field 0) times b=0xC2F0 -> 0x0000.
3. Rounding: a=0x3FC0, b=0x3F81 -> 0x3FC2 with ROUND=1; rebuild with ROUND=0 -> 0x3FC1. a=0x3FFF, b=0x3FFF -> 0x407E for both ROUND settings.
4. Exceptions:
   - a=0x7F00, b=0x4000 -> out_p=0x7F7F, out_ovf=1.
   - a=0xFF00, b=0x4000 -> 0xFF7F, out_ovf=1.
   - a=0x0080, b=0x3F00 -> 0x0000, out_unf=1.
5. Backpressure: stream 6 back-to-back ops with tags 0..5; hold out_ready=0 for 4 cycles mid-stream. Required: in_ready=0 while stalled, out_p/out_tag stable, results emerge in tag order 0..5, none lost or duplicated.
6. Reset mid-flight: issue 3 ops, assert reset on the cycle after the third is accepted. Required: out_valid=0 after the reset edge, and none of the 3 results appear afterwards; a new op issued after reset completes normally with 3-cycle latency.
